// File: rtl/cgra_channel_pipe.sv
// rtl/cgra_channel_pipe.sv - fixed-latency CGRA inter-tile channel with credit-counted FIFO
//
// Purpose: carries CGRAData messages {payload, predicate, bypass} bit-exact from a
// producer tile to a consumer tile. An accepted message spends LATENCY-1 cycles in a
// free-running valid+data pipeline and then lands in a DEPTH-entry circular FIFO.
// Admission is governed by the total in-flight count (pipeline + FIFO), so every
// pipeline output is guaranteed a FIFO slot and the pipeline never has to stall.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clear      synchronous flush of all in-flight messages
//   recv__en   producer push (legal only while recv__rdy=1)
//   recv__msg  incoming message, DATA_W+2 bits
//   recv__rdy  channel can accept this cycle (registered count only)
//   send__en   message delivered this cycle
//   send__msg  FIFO head message, zero when send__en=0
//   send__rdy  consumer can accept
//   count      messages in flight, registered
module cgra_channel_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              recv__en,
    input  logic [DATA_W+1:0] recv__msg,
    output logic              recv__rdy,
    output logic              send__en,
    output logic [DATA_W+1:0] send__msg,
    input  logic              send__rdy,
    output logic [CNT_W-1:0]  count
);

    localparam int MSG_W = DATA_W + 2;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [MSG_W-1:0] mem_q [DEPTH];

    logic             push;
    logic             pop;
    logic             fifo_wr;
    logic [MSG_W-1:0] fifo_wr_msg;

    // Admission looks only at the registered total, so a slot freed by this
    // cycle's pop is not handed out until the next cycle.
    assign recv__rdy = reset && !clear && (count_q < CNT_MAX);
    assign push      = recv__en && recv__rdy;

    assign send__en  = reset && !clear && send__rdy && (fifo_cnt_q != '0);
    assign pop       = send__en;
    assign send__msg = send__en ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    generate
        if (LATENCY <= 1) begin : g_direct
            assign fifo_wr     = push;
            assign fifo_wr_msg = recv__msg;
        end else begin : g_pipe
            localparam int NSTG = LATENCY - 1;

            logic [NSTG-1:0]  vld_q;
            logic [MSG_W-1:0] dat_q [NSTG];

            // Stages shift every cycle; the credit check upstream is what
            // makes this safe without any stall path.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= '0;
                end else if (clear) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= push;
                    for (int i = 1; i < NSTG; i++) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            // Payload needs no reset: it is only consumed alongside its valid.
            always_ff @(posedge clk) begin
                if (push) begin
                    dat_q[0] <= recv__msg;
                end
                for (int i = 1; i < NSTG; i++) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end

            assign fifo_wr     = vld_q[NSTG-1];
            assign fifo_wr_msg = dat_q[NSTG-1];
        end
    endgenerate

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        count_d    = count_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            count_d    = '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            // An arrival while the last entry pops is stored, never bypassed,
            // so the FIFO occupancy simply nets out.
            case ({fifo_wr, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr && !clear) begin
            mem_q[wr_ptr_q] <= fifo_wr_msg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_cgra_channel_pipe.sv
// tb/tb_cgra_channel_pipe.sv - scoreboard bench for cgra_channel_pipe over three configurations
module tb_cgra_channel_pipe;

    localparam int DATA_W = 32;
    localparam int MSG_W  = DATA_W + 2;
    localparam int NCFG   = 3;

    // One in-flight message: its contents and the edge at which it may pop.
    typedef struct {
        logic [MSG_W-1:0] msg;
        int               t;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int cfg, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d: got %h expected %h at %0t", name, cfg, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int L  = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        localparam int D  = (g == 0) ? 2 : 4;
        localparam int CW = $clog2(D + 1);

        logic             rst_n;
        logic             clr;
        logic             ren;
        logic             srdy;
        logic             rdy;
        logic             sen;
        logic [MSG_W-1:0] rmsg;
        logic [MSG_W-1:0] smsg;
        logic [CW-1:0]    cnt;

        ent_t             q[$];
        int               edge_n = 0;
        bit               d_push = 1'b0;
        bit               d_pop  = 1'b0;
        bit               d_clr  = 1'b0;
        logic [MSG_W-1:0] d_msg;
        bit               done   = 1'b0;

        cgra_channel_pipe #(
            .DATA_W (DATA_W),
            .LATENCY(L),
            .DEPTH  (D)
        ) dut (
            .clk      (clk),
            .reset    (rst_n),
            .clear    (clr),
            .recv__en (ren),
            .recv__msg(rmsg),
            .recv__rdy(rdy),
            .send__en (sen),
            .send__msg(smsg),
            .send__rdy(srdy),
            .count    (cnt)
        );

        // Monitor: mid-cycle, derive what the channel must show from the
        // in-flight list, compare, and record this cycle's push/pop/clear.
        always @(negedge clk) begin
            int               sz;
            bit               elig;
            bit               e_rdy;
            bit               e_en;
            logic [MSG_W-1:0] e_msg;
            sz    = q.size();
            elig  = 1'b0;
            e_msg = '0;
            if (sz > 0) elig = (q[0].t <= edge_n + 1);
            e_rdy = rst_n && !clr && (sz < D);
            e_en  = rst_n && !clr && srdy && elig;
            if (e_en) e_msg = q[0].msg;
            chk("recv_rdy", g, 64'(rdy), 64'(e_rdy));
            chk("send_en", g, 64'(sen), 64'(e_en));
            chk("send_msg", g, 64'(smsg), 64'(e_msg));
            chk("count", g, 64'(cnt), 64'(sz));
            chk("protocol", g, 64'(ren && rst_n && !clr && !e_rdy), 64'd0);
            d_push = ren && e_rdy;
            d_pop  = e_en;
            d_clr  = rst_n && clr;
            d_msg  = rmsg;
        end

        always @(posedge clk) begin
            edge_n++;
            if (rst_n) begin
                if (d_clr) begin
                    q.delete();
                end else begin
                    if (d_pop) void'(q.pop_front());
                    if (d_push) q.push_back('{msg: d_msg, t: edge_n + L});
                end
            end
        end

        always @(negedge rst_n) q.delete();

        initial begin
            logic [MSG_W-1:0] tbl [4];
            tbl[0] = {32'hECEBECEB, 2'b11};
            tbl[1] = {32'hAAAAAAAA, 2'b11};
            tbl[2] = {32'h00000001, 2'b10};
            tbl[3] = {32'h00000002, 2'b01};
            rst_n = 1'b0; clr = 1'b0; ren = 1'b0; srdy = 1'b0; rmsg = '0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;

            // back-to-back pushes with the consumer always ready
            srdy = 1'b1;
            for (int i = 0; i < 4; i++) begin
                ren = (q.size() < D); rmsg = tbl[i];
                @(posedge clk); #1;
            end
            ren = 1'b0;
            repeat (L + 2) begin @(posedge clk); #1; end

            // fill with consumer stalled, then drain while offering new pushes
            srdy = 1'b0;
            for (int i = 0; i < D; i++) begin
                ren = (q.size() < D); rmsg = {DATA_W'(32'h11 * (i + 1)), 2'b00};
                @(posedge clk); #1;
            end
            ren = 1'b0;
            repeat (L + 1) begin @(posedge clk); #1; end
            srdy = 1'b1;
            for (int i = 0; i < D + 2; i++) begin
                ren = (q.size() < D); rmsg = {$urandom(), 2'($urandom_range(3))};
                @(posedge clk); #1;
            end
            ren = 1'b0;
            repeat (L + D + 1) begin @(posedge clk); #1; end

            // flush with messages in flight and a push offered during clear
            srdy = 1'b0;
            for (int i = 0; i < 3; i++) begin
                ren = (q.size() < D); rmsg = {DATA_W'(32'h30 + i), 2'b10};
                @(posedge clk); #1;
            end
            ren = 1'b0;
            @(posedge clk); #1;
            clr = 1'b1; ren = 1'b1; rmsg = {32'hDEADBEEF, 2'b11};
            @(posedge clk); #1;
            clr = 1'b0; ren = 1'b0; srdy = 1'b1;
            repeat (L + 4) begin @(posedge clk); #1; end

            // randomized traffic with occasional flushes
            for (int i = 0; i < 400; i++) begin
                srdy = ($urandom_range(3) != 0);
                clr  = ($urandom_range(60) == 0);
                ren  = ($urandom_range(2) != 0) && (q.size() < D);
                rmsg = {$urandom(), 2'($urandom_range(3))};
                @(posedge clk); #1;
            end
            clr = 1'b0; ren = 1'b0; srdy = 1'b1;
            repeat (L + D + 1) begin @(posedge clk); #1; end

            // asynchronous reset off-edge in the middle of a stream
            for (int i = 0; i < 3; i++) begin
                ren = (q.size() < D); rmsg = {$urandom(), 2'b01};
                @(posedge clk); #1;
            end
            @(posedge clk); #3;
            rst_n = 1'b0;
            #1;
            chk("rst_recv_rdy", g, 64'(rdy), 64'd0);
            chk("rst_send_en", g, 64'(sen), 64'd0);
            chk("rst_send_msg", g, 64'(smsg), 64'd0);
            chk("rst_count", g, 64'(cnt), 64'd0);
            ren = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            ren = 1'b1; rmsg = {32'h5A5A1234, 2'b10};
            @(posedge clk); #1;
            ren = 1'b0;
            repeat (L + 3) begin @(posedge clk); #1; end
            done = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        chk("timeout", 0, 64'(cyc >= 20000), 64'd0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
